// File: rtl/aes_pkg.sv
// Shared definitions for the AES-128 round controller: FSM state encoding,
// round count and the key-expansion round-constant table.
// No ports; imported by aes_rcon_rom and aes_round_ctrl.
package aes_pkg;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_ROUND = 2'd1,
    ST_FINAL = 2'd2,
    ST_DONE  = 2'd3
  } aes_state_t;

  localparam int NUM_ROUNDS_AES128 = 10;

  // Round constants for rounds 1..10, entry 0 belongs to round 1.
  localparam logic [7:0] RCON_TABLE [0:9] = '{
    8'h01, 8'h02, 8'h04, 8'h08, 8'h10,
    8'h20, 8'h40, 8'h80, 8'h1B, 8'h36
  };

endpackage

// File: rtl/aes_rcon_rom.sv
// Purely combinational round-constant lookup.
// Ports: idx (round number 0..15) in, rcon (8-bit constant) out;
//        rounds 1..10 map to the table, every other index gives 8'h00.
module aes_rcon_rom
  import aes_pkg::*;
(
  input  logic [3:0] idx,
  output logic [7:0] rcon
);

  always_comb begin
    rcon = 8'h00;
    if (idx >= 4'd1 && idx <= 4'd10) begin
      rcon = RCON_TABLE[idx - 4'd1];
    end
  end

endmodule

// File: rtl/aes_round_ctrl.sv
// AES-128 round sequencer: drives load/select strobes for an external
// state/round-key datapath; one block takes 11 load cycles, out_valid on cycle 11.
// Ports: clk, rst_n (async active-low), in_valid/in_ready, out_valid/out_ready,
//        state_load, key_load, sel_init, sel_mix, round_idx, rcon, busy.
// Optional abort input when AES_ROUND_CTRL_ABORT_EN is defined.
module aes_round_ctrl
  import aes_pkg::*;
#(
  parameter int NUM_ROUNDS = NUM_ROUNDS_AES128
) (
  input  logic       clk,
  input  logic       rst_n,
`ifdef AES_ROUND_CTRL_ABORT_EN
  input  logic       abort,
`endif
  input  logic       in_valid,
  output logic       in_ready,
  output logic       out_valid,
  input  logic       out_ready,
  output logic       state_load,
  output logic       key_load,
  output logic       sel_init,
  output logic       sel_mix,
  output logic [3:0] round_idx,
  output logic [7:0] rcon,
  output logic       busy
);

  // Last round that still uses MixColumns; the following cycle is FINAL.
  localparam logic [3:0] LAST_MIX_ROUND = 4'(NUM_ROUNDS - 1);

  aes_state_t state, state_nxt;
  logic [3:0] round_nxt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= ST_IDLE;
      round_idx <= 4'd0;
    end else begin
      state     <= state_nxt;
      round_idx <= round_nxt;
    end
  end

  always_comb begin
    state_nxt  = state;
    round_nxt  = round_idx;
    in_ready   = 1'b0;
    out_valid  = 1'b0;
    state_load = 1'b0;
    key_load   = 1'b0;
    sel_init   = 1'b0;
    sel_mix    = 1'b0;
    busy       = 1'b1;

    unique case (state)
      ST_IDLE: begin
        busy      = 1'b0;
        round_nxt = 4'd0;
        // Gating with rst_n keeps every strobe low while reset is held,
        // even though the async reset already parks the FSM in IDLE.
        in_ready  = rst_n;
        if (in_valid && rst_n) begin
          sel_init   = 1'b1;
          state_load = 1'b1;
          key_load   = 1'b1;
          state_nxt  = ST_ROUND;
          round_nxt  = 4'd1;
        end
      end
      ST_ROUND: begin
        state_load = 1'b1;
        key_load   = 1'b1;
        sel_mix    = 1'b1;
        round_nxt  = round_idx + 4'd1;
        if (round_idx == LAST_MIX_ROUND) begin
          state_nxt = ST_FINAL;
        end
      end
      ST_FINAL: begin
        state_load = 1'b1;
        key_load   = 1'b1;
        state_nxt  = ST_DONE;
        round_nxt  = 4'd0;
      end
      ST_DONE: begin
        out_valid = 1'b1;
        if (out_ready) begin
          state_nxt = ST_IDLE;
        end
      end
      default: begin
        state_nxt = ST_IDLE;
        round_nxt = 4'd0;
      end
    endcase

`ifdef AES_ROUND_CTRL_ABORT_EN
    // Abort drops the block: no strobes this cycle, and out_valid is
    // withdrawn so a consumer cannot take a discarded result.
    if (abort && state != ST_IDLE) begin
      state_load = 1'b0;
      key_load   = 1'b0;
      sel_mix    = 1'b0;
      out_valid  = 1'b0;
      state_nxt  = ST_IDLE;
      round_nxt  = 4'd0;
    end
`endif
  end

  aes_rcon_rom u_rcon (
    .idx  (round_idx),
    .rcon (rcon)
  );

endmodule

// File: tb/tb_aes_round_ctrl.sv
module tb_aes_round_ctrl;

  typedef struct packed {
    logic       in_ready;
    logic       out_valid;
    logic       state_load;
    logic       key_load;
    logic       sel_init;
    logic       sel_mix;
    logic       busy;
    logic [3:0] round_idx;
    logic [7:0] rcon;
  } obs_t;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       abort = 1'b0;
  logic       in_valid = 1'b0;
  logic       in_ready;
  logic       out_valid;
  logic       out_ready = 1'b0;
  logic       state_load;
  logic       key_load;
  logic       sel_init;
  logic       sel_mix;
  logic [3:0] round_idx;
  logic [7:0] rcon;
  logic       busy;

  int checks = 0;
  int failures = 0;
  int completions = 0;
  int exp_completions = 0;
  obs_t exp_q[$];
  int   cyc_q[$];

  always #5 clk = ~clk;

  aes_round_ctrl #(.NUM_ROUNDS(10)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
`ifdef AES_ROUND_CTRL_ABORT_EN
    .abort      (abort),
`endif
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .out_valid  (out_valid),
    .out_ready  (out_ready),
    .state_load (state_load),
    .key_load   (key_load),
    .sel_init   (sel_init),
    .sel_mix    (sel_mix),
    .round_idx  (round_idx),
    .rcon       (rcon),
    .busy       (busy)
  );

  // Round constant from GF(2^8) doubling: rc(1)=1, rc(n)=xtime(rc(n-1)).
  function automatic logic [7:0] rc(int n);
    logic [8:0] r;
    r = 9'h001;
    for (int i = 1; i < n; i++) begin
      r = {r[7:0], 1'b0};
      if (r[8]) r = r ^ 9'h11B;
    end
    return r[7:0];
  endfunction

  // Reference: ph = -1 idle, 1..10 = round being computed, 11 = result held.
  function automatic obs_t expect_obs(int ph, logic iv, logic rs, logic ab);
    obs_t e;
    e = '0;
    if (!rs) return e;
    if (ph < 0) begin
      e.in_ready = 1'b1;
      if (iv) begin
        e.sel_init   = 1'b1;
        e.state_load = 1'b1;
        e.key_load   = 1'b1;
      end
      return e;
    end
    e.busy = 1'b1;
    if (ph <= 10) begin
      e.round_idx = 4'(ph);
      e.rcon      = rc(ph);
    end
    if (ab) return e;
    if (ph <= 10) begin
      e.state_load = 1'b1;
      e.key_load   = 1'b1;
      e.sel_mix    = (ph < 10);
    end else begin
      e.out_valid = 1'b1;
    end
    return e;
  endfunction

  // Monitor: compares every observed cycle against the queued expectation.
  always @(negedge clk) begin
    obs_t act, exp_o;
    int   c;
    act = '{in_ready, out_valid, state_load, key_load, sel_init, sel_mix,
            busy, round_idx, rcon};
    if (exp_q.size() > 0) begin
      exp_o = exp_q.pop_front();
      c = cyc_q.pop_front();
      checks++;
      if (act !== exp_o) begin
        failures++;
        $display("FAIL cycle_outputs cyc=%0d actual=%h required=%h (rdy,ov,sl,kl,init,mix,busy,idx,rcon)",
                 c, act, exp_o);
      end
    end
    if (out_valid && out_ready) completions++;
  end

  initial begin
    int   ph = -1;
    int   rst_hold = 2;
    bit   directed_rst_done = 0;
    int   n_cycles = 3000;
    for (int cyc = 0; cyc < n_cycles; cyc++) begin
      @(posedge clk);
      // Advance reference with the inputs that were stable over this edge.
      if (!rst_n) ph = -1;
      else if (abort && ph >= 1) ph = -1;
      else if (ph < 0) ph = in_valid ? 1 : -1;
      else if (ph <= 10) ph = ph + 1;
      else if (out_ready) ph = -1;
      #1;
      if (cyc >= n_cycles - 30) begin
        rst_n = 1'b1; abort = 1'b0; in_valid = 1'b0; out_ready = 1'b1;
      end else begin
        if (rst_hold == 0 && ph >= 1) begin
          if (!directed_rst_done && ph == 6) begin
            rst_hold = 1;
            directed_rst_done = 1;
          end else if ($urandom_range(0, 79) == 0) begin
            rst_hold = $urandom_range(1, 3);
          end
        end
        if (rst_hold > 0) begin
          rst_n = 1'b0;
          rst_hold--;
        end else begin
          rst_n = 1'b1;
        end
        in_valid  = ($urandom_range(0, 1) == 1);
        out_ready = (cyc < 40) ? 1'b1 : ($urandom_range(0, 9) < 6);
`ifdef AES_ROUND_CTRL_ABORT_EN
        abort = ($urandom_range(0, 49) == 0);
`else
        abort = 1'b0;
`endif
      end
      if (rst_n && !abort && ph == 11 && out_ready) exp_completions++;
      exp_q.push_back(expect_obs(ph, in_valid, rst_n, abort));
      cyc_q.push_back(cyc);
    end
    @(posedge clk);
    #6;
    checks++;
    if (exp_q.size() != 0) begin
      failures++;
      $display("FAIL scoreboard_drain actual=%0d required=0", exp_q.size());
    end
    checks++;
    if (completions != exp_completions || exp_completions == 0) begin
      failures++;
      $display("FAIL completions actual=%0d required=%0d (nonzero)", completions, exp_completions);
    end
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/aes_round_ctrl.md
AES_ROUND_CTRL -- requirements
Module: aes_round_ctrl

Interface
REQ-001 Parameter NUM_ROUNDS, default 10, SHALL set the AES round count; only 10 (AES-128) is supported.
REQ-002 clk  input  1  SHALL be the single clock; all state updates on its rising edge.
REQ-003 rst_n  input  1  SHALL be the reset: asynchronous, active-low.
REQ-004 in_valid  input  1  SHALL indicate that plaintext and cipher key are present on the external datapath.
REQ-005 in_ready  output  1  SHALL indicate that the controller accepts a new block.
REQ-006 out_valid  output  1  SHALL indicate that the external state register holds the ciphertext.
REQ-007 out_ready  input  1  SHALL indicate that the consumer takes the ciphertext.
REQ-008 state_load  output  1  SHALL be the write enable for the external state register.
REQ-009 key_load  output  1  SHALL be the write enable for the external round-key register.
REQ-010 sel_init  output  1  SHALL select the initial path: state = plaintext XOR cipher key, and key register = cipher key.
REQ-011 sel_mix  output  1  SHALL enable MixColumns in the round datapath (0 = bypass).
REQ-012 round_idx  output  4  SHALL give the current round number, 0..NUM_ROUNDS.
REQ-013 rcon  output  8  SHALL give the key-expansion round constant for round_idx.
REQ-014 busy  output  1  SHALL be high in every state except IDLE.

Function
REQ-015 The FSM SHALL have four states: IDLE, ROUND, FINAL, DONE.
REQ-016 IDLE: in_ready=1, and all other outputs are 0 except as stated in REQ-017.
REQ-017 When in IDLE with in_valid=1, outputs SHALL be sel_init=1, state_load=1, key_load=1 and round_idx=0 in the same cycle; next state is ROUND with round_idx=1.
REQ-018 ROUND: state_load=1, key_load=1, sel_mix=1; round_idx increments by 1 per cycle; transition to FINAL when round_idx==NUM_ROUNDS-1.
REQ-019 FINAL: state_load=1, key_load=1, sel_mix=0, round_idx=NUM_ROUNDS; next state is DONE.
REQ-020 DONE: out_valid=1, held with no load enables until out_ready=1; then the next state is IDLE.
REQ-021 rcon SHALL be 01,02,04,08,10,20,40,80,1B,36 (hex) for round_idx 1..10, and 00 otherwise.
REQ-022 Latency SHALL be fixed: input handshake in cycle 0, out_valid first high in cycle 11.
REQ-023 in_ready SHALL be 0 outside IDLE, so a new block is never accepted while one is in flight; in_valid outside IDLE is ignored.
REQ-024 out_ready outside DONE SHALL be ignored.
REQ-025 round_idx SHALL never exceed NUM_ROUNDS and SHALL return to 0 in IDLE.

Reset
REQ-026 rst_n low SHALL force, asynchronously: state=IDLE, round_idx=0, out_valid=0, busy=0, and all load enables 0.
REQ-027 A reset asserted mid-operation SHALL discard the block; no out_valid follows.
REQ-028 After release, in_ready=1 SHALL be available on the first clock edge.

Configuration
REQ-029 With macro AES_ROUND_CTRL_ABORT_EN defined, an input port abort (1 bit) SHALL exist.
REQ-030 With the macro, abort=1 in ROUND, FINAL or DONE SHALL go to IDLE at the next edge, with no load enables in that cycle; abort in IDLE SHALL have no effect.
REQ-031 Without the macro, the abort port SHALL be absent and the behaviour is as in REQ-015..REQ-025.

Structure
REQ-032 A shared package aes_pkg SHALL hold the FSM state enum, the NUM_ROUNDS_AES128 constant (10) and the 10-entry RCON table.
REQ-033 The rcon lookup SHALL be a sub-module aes_rcon_rom (4-bit index in, 8-bit constant out), purely combinational.
REQ-034 The XOR/SubBytes/ShiftRows/MixColumns datapath SHALL stay outside this block; the controller holds no data.

Verification
REQ-035 Single block: in_valid=1 for 1 cycle with out_ready=1 -> state_load high cycles 0..10; sel_mix=1 in cycles 1..9 only; out_valid in cycle 11; idle in cycle 12.
REQ-036 Back-pressure: out_ready=0 for 5 cycles after out_valid -> out_valid holds; no load enables; in_ready=0 throughout.
REQ-037 rcon check: one block -> rcon sequence 01,02,04,08,10,20,40,80,1B,36 in cycles 1..10.
REQ-038 Mid-run reset: rst_n low at cycle 6 -> outputs zero immediately; no out_valid; next block completes normally.
REQ-039 Abort (macro defined): abort=1 at cycle 4 -> IDLE at cycle 5; no out_valid; new block accepted in cycle 5.
REQ-040 Golden run: datapath with FIPS-197 vector (key 000102..0F, plaintext 00112233..FF) -> ciphertext 69C4E0D86A7B0430D8CDB78070B4C55A.
